// File: rtl/if_id_skid_buf.sv
// IF/ID pipeline elastic buffer: a main register feeding decode plus one skid entry,
// so in_ready and out_valid come only from registered state.
module if_id_skid_buf #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    input  logic            flush,
    output logic [1:0]      count
);

    // Encoding equals occupancy, so count is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [XLEN-1:0] main_pc_reg;
    logic [XLEN-1:0] main_instr_reg;
    logic [XLEN-1:0] skid_pc_reg;
    logic [XLEN-1:0] skid_instr_reg;

    logic push;
    logic pop;
    logic main_load;
    logic main_from_skid;
    logic skid_load;

    assign in_ready  = (state_reg != SKID);
    assign out_valid = (state_reg != EMPTY);
    assign count     = state_reg;
    assign out_pc    = main_pc_reg;
    assign out_instr = main_instr_reg;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (push) begin
                        main_load  = 1'b1;
                        state_next = FULL;
                    end
                end
                FULL: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        skid_load  = 1'b1;
                        state_next = SKID;
                    end else if (pop) begin
                        state_next = EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        main_from_skid = 1'b1;
                        state_next     = FULL;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // A flush leaves out_pc alone so decode still sees where the redirect came from.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_pc_reg    <= '0;
            main_instr_reg <= NOP_INSTR;
            skid_pc_reg    <= '0;
            skid_instr_reg <= '0;
        end else if (flush) begin
            main_instr_reg <= NOP_INSTR;
        end else begin
            if (main_load) begin
                main_pc_reg    <= in_pc;
                main_instr_reg <= in_instr;
            end else if (main_from_skid) begin
                main_pc_reg    <= skid_pc_reg;
                main_instr_reg <= skid_instr_reg;
            end
            if (skid_load) begin
                skid_pc_reg    <= in_pc;
                skid_instr_reg <= in_instr;
            end
        end
    end

endmodule

// File: tb/tb_if_id_skid_buf.sv
// Bench for if_id_skid_buf: a FIFO-queue model of the buffer checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_id_skid_buf;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
    logic            flush;
    logic [1:0]      count;

    if_id_skid_buf #(.XLEN(XLEN), .NOP_INSTR(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .flush     (flush),
        .count     (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: the held words as a queue, plus whatever the output registers last showed.
    logic [31:0] q_pc[$];
    logic [31:0] q_in[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_pc.delete();
        q_in.delete();
        m_pc    = '0;
        m_instr = NOP;
    endtask

    // Advances the model across one rising edge using the inputs currently driven.
    task automatic model_step();
        bit do_push;
        bit do_pop;
        if (flush) begin
            q_pc.delete();
            q_in.delete();
            m_instr = NOP;
        end else begin
            do_push = in_valid && (q_pc.size() < 2);
            do_pop  = (q_pc.size() > 0) && out_ready;
            if (do_pop) begin
                void'(q_pc.pop_front());
                void'(q_in.pop_front());
            end
            if (do_push) begin
                q_pc.push_back(in_pc);
                q_in.push_back(in_instr);
            end
            if (q_pc.size() > 0) begin
                m_pc    = q_pc[0];
                m_instr = q_in[0];
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, q_pc.size() > 0});
            check("in_ready",  {31'd0, in_ready},  {31'd0, q_pc.size() < 2});
            check("count",     {30'd0, count},     q_pc.size());
            check("out_pc",    out_pc,    m_pc);
            check("out_instr", out_instr, m_instr);
        end
    end

    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
        @(negedge clk);
        #1;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        model_step();
        @(posedge clk);
        #1;
        $display("cyc v=%0d pc=%h rdy=%0d fl=%0d -> ov=%0d ir=%0d cnt=%0d opc=%h oin=%h",
                 v, pc, ordy, fl, out_valid, in_ready, count, out_pc, out_instr);
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst in_ready",  {31'd0, in_ready},  32'd1);
        check("rst count",     {30'd0, count},     32'd0);
        check("rst out_pc",    out_pc,    32'd0);
        check("rst out_instr", out_instr, NOP);
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b1;

        // Single push, one-cycle fall-through
        cyc(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0);
        check("first out_valid", {31'd0, out_valid}, 32'd1);
        check("first out_pc",    out_pc,    32'h100);
        check("first out_instr", out_instr, 32'h00500093);
        check("first count",     {30'd0, count}, 32'd1);

        // Streaming at one word per cycle
        cyc(1'b1, 32'h104, 32'h00600113, 1'b1, 1'b0);
        check("stream 104", out_pc, 32'h104);
        check("stream ir",  {31'd0, in_ready}, 32'd1);
        cyc(1'b1, 32'h108, 32'h00700193, 1'b1, 1'b0);
        check("stream 108", out_pc, 32'h108);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain ov",   {31'd0, out_valid}, 32'd0);
        check("drain hold", out_pc, 32'h108);

        // Fill to two entries, then drain in order
        cyc(1'b1, 32'h200, 32'h11111111, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 32'h22222222, 1'b0, 1'b0);
        check("skid count", {30'd0, count}, 32'd2);
        check("skid ir",    {31'd0, in_ready}, 32'd0);
        check("skid head",  out_pc, 32'h200);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("drain 204",  out_pc, 32'h204);
        check("drain 204i", out_instr, 32'h22222222);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush from SKID while a word is offered
        cyc(1'b1, 32'h210, 32'h33333333, 1'b0, 1'b0);
        cyc(1'b1, 32'h214, 32'h44444444, 1'b0, 1'b0);
        cyc(1'b1, 32'h300, 32'h55555555, 1'b0, 1'b1);
        check("flush count", {30'd0, count}, 32'd0);
        check("flush ov",    {31'd0, out_valid}, 32'd0);
        check("flush instr", out_instr, NOP);
        check("flush pc",    out_pc, 32'h210);
        cyc(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("no 300", out_pc, 32'h210);

        // Simultaneous push and pop while FULL
        cyc(1'b1, 32'h400, 32'h66666666, 1'b0, 1'b0);
        cyc(1'b1, 32'h404, 32'h77777777, 1'b1, 1'b0);
        check("pp count", {30'd0, count}, 32'd1);
        check("pp pc",    out_pc, 32'h404);

        // Asynchronous reset between edges while in SKID
        cyc(1'b1, 32'h408, 32'h88888888, 1'b0, 1'b0);
        check("pre-rst count", {30'd0, count}, 32'd2);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        check("async ov",    {31'd0, out_valid}, 32'd0);
        check("async ir",    {31'd0, in_ready},  32'd1);
        check("async count", {30'd0, count},     32'd0);
        check("async instr", out_instr, NOP);
        @(negedge clk);
        #1;
        reset = 1'b1;
        cyc(1'b1, 32'h500, 32'h99999999, 1'b0, 1'b0);
        check("post-rst pc",    out_pc, 32'h500);
        check("post-rst count", {30'd0, count}, 32'd1);

        // Mixed traffic checked by the model alone
        for (int i = 0; i < 80; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_skid_buf.md
IF_ID_SKID_BUF -- requirements
Module: if_id_skid_buf

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of the PC and instruction datapaths.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction word presented when the buffer is empty after reset or flush.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port in_valid  input  1  fetch stage presents pc/instr.
REQ-006 SHALL have port in_ready  output  1  buffer accepts a word this cycle.
REQ-007 SHALL have port in_pc  input  XLEN  fetched PC.
REQ-008 SHALL have port in_instr  input  XLEN  fetched instruction.
REQ-009 SHALL have port out_valid  output  1  decode-side word is valid.
REQ-010 SHALL have port out_ready  input  1  decode stage consumes the word this cycle.
REQ-011 SHALL have port out_pc  output  XLEN  PC to decode.
REQ-012 SHALL have port out_instr  output  XLEN  instruction to decode.
REQ-013 SHALL have port flush  input  1  branch/jump redirect; discard all held words.
REQ-014 SHALL have port count  output  2  occupancy, 0..2.

Function
REQ-015 SHALL implement a 2-entry elastic buffer: main register (drives out_*) plus a skid register.
REQ-016 SHALL use three states: EMPTY (count 0), FULL (main only, count 1), SKID (main + skid, count 2).
REQ-017 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready, both sampled at the rising edge of clk.
REQ-018 SHALL drive in_ready = (state != SKID) and out_valid = (state != EMPTY), decoded from state registers only, with no combinational path from in_valid or out_ready.
REQ-019 In EMPTY, push SHALL load main from in_* and go to FULL.
REQ-020 In FULL, push & pop SHALL load main from in_* and stay in FULL; push & !pop SHALL load skid from in_* and go to SKID; !push & pop SHALL go to EMPTY; otherwise state holds.
REQ-021 In SKID, pop SHALL move skid to main and go to FULL; otherwise state holds (no push is possible).
REQ-022 SHALL have a fall-through latency of exactly 1 cycle (push at edge N -> out_valid high after edge N) and sustain 1 word/cycle when out_ready is held high.
REQ-023 SHALL preserve word order: no word is duplicated, dropped or reordered except by flush.
REQ-024 flush SHALL take priority over push and pop: at the next edge the state goes to EMPTY, out_instr goes to NOP_INSTR, out_pc holds, and any word presented that cycle is discarded even though in_ready may be high.
REQ-025 When out_valid = 0 and no flush occurs, out_pc and out_instr SHALL hold their last values.
REQ-026 The skid register SHALL update only on FULL & push & !pop, and main only on a push into EMPTY or FULL or on a SKID pop.

Reset
REQ-027 While reset = 0, the block SHALL asynchronously force state EMPTY, out_valid 0, in_ready 1, count 0, out_pc 0, out_instr NOP_INSTR, and skid contents 0.
REQ-028 Reset asserted mid-operation SHALL discard all held words, and the first edge after reset = 1 SHALL behave as an EMPTY cycle.

Verification
REQ-029 Reset then push pc=0x100/instr=0x00500093 with out_ready=1 -> out_valid=1, out_pc=0x100 the next cycle; count 1.
REQ-030 Stream 0x100,0x104,0x108 with out_ready=1 every cycle -> one word out per cycle, in order, in_ready stays 1.
REQ-031 out_ready=0, push 0x200 then 0x204 -> count 2, in_ready=0, out_pc=0x200; raise out_ready -> 0x200 then 0x204 emerge on consecutive cycles.
REQ-032 In SKID, assert flush with in_valid=1 (pc 0x300) -> next cycle count 0, out_valid 0, out_instr 0x00000013; 0x300 never appears at the output.
REQ-033 In FULL, push & pop in the same cycle (0x400 out, 0x404 in) -> stays FULL, out_pc=0x404, count 1.
REQ-034 Drive reset=0 asynchronously between edges while in SKID -> out_valid drops immediately; in_ready=1, count 0.
